usb_ep_buf_mw: RTL
==================

# usb_ep_buf_mw

Single-clock, multi-width USB endpoint buffer with independent read and write ports. The core is a 32-bit-wide inferred RAM, and each port adapts to 8, 16 or 32 bits through byte-lane masking and read-lane selection. It adds three things: an emulated read enable with output hold, synchronous reset of read-side state, and write-to-read bypass on same-word collisions. It sits between the USB packet engine (byte side) and the bus interface (word side), holding endpoint packet data.

## Interface

- `RWIDTH`, 8: read port width in bits; legal values 8/16/32.
- `WWIDTH`, 8: write port width in bits; legal values 8/16/32.
- `AWIDTH`, 11: byte address width. The buffer holds 2^AWIDTH bytes as 2^(AWIDTH-2) words of 32 bits.
- `ARW`, AWIDTH-log2(RWIDTH/8): read address width, derived.
- `AWW`, AWIDTH-log2(WWIDTH/8): write address width, derived.
- `clk`  in  1  sole clock for both ports.
- `rst`  in  1  reset, synchronous and active-high.
- `rd_addr_0`  in  ARW  read address in RWIDTH units; sampled when `rd_en_0`=1.
- `rd_en_0`  in  1  read request.
- `rd_data_1`  out  RWIDTH  read data, one cycle after the request; held between reads.
- `wr_addr_0`  in  AWW  write address in WWIDTH units.
- `wr_data_0`  in  WWIDTH  write data.
- `wr_en_0`  in  1  write strobe.

## Operation

- **Word/lane split, write side:** word index = `wr_addr_0` >> log2(32/WWIDTH). Lane bits are the low log2(32/WWIDTH) bits.
- **Word/lane split, read side:** the same rule applies to `rd_addr_0` with RWIDTH.
- **Write mask:**
  - WWIDTH=8: one of 4 byte-enable bits set; `wr_data_0` replicated 4×.
  - WWIDTH=16: byte pair {1,0} or {3,2} enabled; data replicated 2×.
  - WWIDTH=32: all 4 bytes enabled.
  - Only enabled bytes are modified.
- **Read:** with `rd_en_0`=1, the addressed 32-bit word is read and the lane index is registered. `rd_data_1` = word[RWIDTH*lane +: RWIDTH]. Lane 0 sits in the least significant bits (little-endian).
- **Hold:**
  - In the cycle after a read, output comes directly from RAM.
  - Otherwise output comes from a save register, loaded with the last RAM output whenever a read completed.
  - `rd_data_1` never changes without a preceding `rd_en_0`, even if the RAM is written later.
- **Collision:** if `rd_en_0` and `wr_en_0` target the same word in the same cycle, the read returns new data in the written bytes and old data in the others (write-first bypass per byte). Different words have no interaction.
- **Reset:**
  - Clears the save register, the lane register and the read-valid flag, so `rd_data_1` = 0 from the cycle after `rst` until the first post-reset read.
  - RAM contents are not reset and survive `rst`.
  - Requests presented in a cycle with `rst`=1 are ignored, both read and write.
- **Addresses:** no range error is possible (widths are exact). Top address 2^ARW-1 reads the last lane of the last word. Address arithmetic wraps naturally in the caller.
- **Elaboration:** illegal widths cause an elaboration error (generate-time check). They are not silently truncated.

## Timing

- Write: takes effect at the rising edge where `wr_en_0`=1. A read of that location issued the next cycle sees the data.
- Read: latency is 1 cycle. The request is at edge N, and `rd_data_1` is valid after edge N, i.e. during cycle N+1. It stays stable until the cycle after the next request.
- Back-to-back reads every cycle give full throughput, one result per cycle.
- Reset priority: `rst` overrides `rd_en_0` and `wr_en_0` in the same cycle. `rd_data_1` = 0 in the next cycle.
- There are no combinational paths from inputs to `rd_data_1`. The output is driven only by registers and the RAM output register, plus a lane mux selected by a register.

## Test plan

- **Byte write, word read:** WWIDTH=8, RWIDTH=32. Write 0x11,0x22,0x33,0x44 to byte addresses 0..3, then read word 0 → `rd_data_1`=0x44332211 one cycle after `rd_en_0`.
- **Word write, byte read:** WWIDTH=32, RWIDTH=8. Write 0xDEADBEEF to word 5, then read byte addresses 20..23 back-to-back → 0xEF,0xBE,0xAD,0xDE on consecutive cycles.
- **Hold:** after reading 0xA5, deassert `rd_en_0` for 10 cycles and write a different value to the same address → `rd_data_1` stays 0xA5 throughout. The next read returns the new value.
- **Collision:** WWIDTH=16, RWIDTH=32. Word 2 = 0x12345678. In the same cycle, write 0xCAFE to halfword address 5 and read word 2 → 0xCAFE5678.
- **Reset:** read 0xFFFFFFFF, then assert `rst` for 1 cycle with `rd_en_0`=1 → `rd_data_1`=0 the next cycle. A post-reset read of the same word returns 0xFFFFFFFF (RAM preserved).
- **Top address:** WWIDTH=RWIDTH=8, AWIDTH=11. Write 0x5A to byte 2047 and 0x3C to byte 0 → reads return 0x5A and 0x3C with no aliasing.

Source files
------------

// File: rtl/usb_ep_buf_mw.sv
// Multi-width USB endpoint buffer: 32-bit word RAM with 8/16/32-bit read and write ports,
// held read output, synchronous read-side reset and per-byte write-first bypass.
module usb_ep_buf_mw #(
   parameter int unsigned RWIDTH = 8,
   parameter int unsigned WWIDTH = 8,
   parameter int unsigned AWIDTH = 11,
   parameter int unsigned ARW    = AWIDTH - $clog2(RWIDTH / 8),
   parameter int unsigned AWW    = AWIDTH - $clog2(WWIDTH / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ARW-1:0]    rd_addr_0,
   input  logic              rd_en_0,
   output logic [RWIDTH-1:0] rd_data_1,
   input  logic [AWW-1:0]    wr_addr_0,
   input  logic [WWIDTH-1:0] wr_data_0,
   input  logic              wr_en_0
);

   localparam int unsigned WAW   = AWIDTH - 2;
   localparam int unsigned DEPTH = 1 << WAW;
   localparam int unsigned RLB   = $clog2(32 / RWIDTH);
   localparam int unsigned WLB   = $clog2(32 / WWIDTH);
   localparam int unsigned RLW   = (RLB == 0) ? 1 : RLB;

   if (RWIDTH != 8 && RWIDTH != 16 && RWIDTH != 32) begin : g_bad_rwidth
      $error("usb_ep_buf_mw: RWIDTH must be 8, 16 or 32");
   end
   if (WWIDTH != 8 && WWIDTH != 16 && WWIDTH != 32) begin : g_bad_wwidth
      $error("usb_ep_buf_mw: WWIDTH must be 8, 16 or 32");
   end
   if (AWIDTH < 3) begin : g_bad_awidth
      $error("usb_ep_buf_mw: AWIDTH must be at least 3");
   end

   logic [31:0]       r_mem [DEPTH];
   logic [31:0]       r_ram_q;
   logic              r_rd_vld;
   logic [RLW-1:0]    r_lane;
   logic [RWIDTH-1:0] r_save;

   logic [WAW-1:0]    w_wr_word;
   logic [WAW-1:0]    w_rd_word;
   logic [3:0]        w_wr_be;
   logic [31:0]       w_wr_mask;
   logic [31:0]       w_wr_data;
   logic [RLW-1:0]    w_rd_lane;
   logic [31:0]       w_rd_word_q;
   logic [31:0]       w_rd_mix;
   logic [RWIDTH-1:0] w_sel;
   logic              w_wr_act;
   logic              w_rd_act;
   logic              w_hit;

   assign w_wr_word = wr_addr_0[AWW-1:WLB];
   assign w_rd_word = rd_addr_0[ARW-1:RLB];
   assign w_wr_data = {(32 / WWIDTH){wr_data_0}};
   assign w_wr_mask = {{8{w_wr_be[3]}}, {8{w_wr_be[2]}}, {8{w_wr_be[1]}}, {8{w_wr_be[0]}}};
   assign w_wr_act  = wr_en_0 & ~rst;
   assign w_rd_act  = rd_en_0 & ~rst;
   assign w_hit     = w_wr_act && (w_wr_word == w_rd_word);

   // Byte enables from the write lane bits
   if (WWIDTH == 8) begin : g_wbe8
      assign w_wr_be = 4'b0001 << wr_addr_0[1:0];
   end else if (WWIDTH == 16) begin : g_wbe16
      assign w_wr_be = wr_addr_0[0] ? 4'b1100 : 4'b0011;
   end else begin : g_wbe32
      assign w_wr_be = 4'b1111;
   end

   if (RLB == 0) begin : g_rlane0
      assign w_rd_lane = 1'b0;
      assign w_sel     = r_ram_q;
   end else begin : g_rlane
      assign w_rd_lane = rd_addr_0[RLB-1:0];
      assign w_sel     = r_ram_q[RWIDTH*r_lane +: RWIDTH];
   end

   // Write-first merge: written bytes of a same-word write replace the stored ones
   assign w_rd_word_q = r_mem[w_rd_word];
   assign w_rd_mix    = w_hit ? ((w_rd_word_q & ~w_wr_mask) | (w_wr_data & w_wr_mask))
                              : w_rd_word_q;

   always_ff @(posedge clk) begin
      if (w_wr_act) begin
         r_mem[w_wr_word] <= (r_mem[w_wr_word] & ~w_wr_mask) | (w_wr_data & w_wr_mask);
      end
      if (w_rd_act) begin
         r_ram_q <= w_rd_mix;
      end
   end

   // Read-side state; the save register captures each completed read for holding
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_vld <= 1'b0;
         r_lane   <= '0;
         r_save   <= '0;
      end else begin
         r_rd_vld <= rd_en_0;
         if (rd_en_0) begin
            r_lane <= w_rd_lane;
         end
         if (r_rd_vld) begin
            r_save <= w_sel;
         end
      end
   end

   assign rd_data_1 = r_rd_vld ? w_sel : r_save;

endmodule
